// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: picks one of two writeback requesters per cycle
// (round-robin on contention), registers the winner onto the register-file
// write port with a fixed 1-cycle latency, and keeps a per-register
// pending scoreboard that issue sets and writeback acceptance clears.

// One scoreboard bit: flush clears, set beats clear on the same edge.
module rf_wb_sb_bit (
    input  logic clk,
    input  logic nrst,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic busy
);

    // A same-edge set means a newer producer was issued, so it must win.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      busy <= 1'b0;
        else if (flush) busy <= 1'b0;
        else if (set)   busy <= 1'b1;
        else if (clr)   busy <= 1'b0;
    end

endmodule

module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req0_valid,
    input  logic [ADDR_W-1:0]       req0_addr,
    input  logic [DATA_W-1:0]       req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [ADDR_W-1:0]       req1_addr,
    input  logic [DATA_W-1:0]       req1_data,
    output logic                    req1_ready,
    input  logic                    flush,
    input  logic                    sb_set_en,
    input  logic [ADDR_W-1:0]       sb_set_addr,
    output logic                    rf_wr_en,
    output logic [ADDR_W-1:0]       rf_wr_addr,
    output logic [DATA_W-1:0]       rf_wr_data,
    output logic [(2**ADDR_W)-1:0]  sb_busy
);

    localparam int NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    wb_req_t req0, req1, acc, wr_q;
    logic    last_grant;   // 0 = req0 won last, 1 = req1 won last
    logic    hs0, hs1, hs;
    logic    wr_vld_in;
    logic    wr_vld_q;

    assign req0 = '{addr: req0_addr, data: req0_data};
    assign req1 = '{addr: req1_addr, data: req1_data};

    // Ready is purely combinational so the requester sees the grant in the
    // same cycle; on contention the one that did not win last time goes.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!flush) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign hs0       = req0_valid & req0_ready;
    assign hs1       = req1_valid & req1_ready;
    assign hs        = hs0 | hs1;
    assign acc       = hs1 ? req1 : req0;
    // Writes to register 0 are accepted but never reach the register file.
    assign wr_vld_in = hs && (acc.addr != '0);

    // Round-robin pointer; reset value makes req0 win the first contention.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)   last_grant <= 1'b1;
        else if (hs) last_grant <= hs1;
    end

    // Write-port stage: enable is a single-cycle pulse, addr/data hold.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_vld_q <= 1'b0;
            wr_q     <= '0;
        end else begin
            wr_vld_q <= wr_vld_in;
            if (hs) wr_q <= acc;
        end
    end

    assign rf_wr_en   = wr_vld_q;
    assign rf_wr_addr = wr_q.addr;
    assign rf_wr_data = wr_q.data;

    // Register 0 is hardwired and can never be pending.
    assign sb_busy[0] = 1'b0;

    // One scoreboard bit per architectural register.
    genvar i;
    generate
        for (i = 1; i < NREG; i++) begin : g_sb
            rf_wb_sb_bit u_sb (
                .clk   (clk),
                .nrst  (nrst),
                .flush (flush),
                .set   (sb_set_en && (sb_set_addr == ADDR_W'(i))),
                .clr   (hs && (acc.addr == ADDR_W'(i))),
                .busy  (sb_busy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset corner sequence,
// then randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, sb_set_addr, rf_wr_addr;
    logic [DW-1:0] req0_data, req1_data, rf_wr_data;
    logic          flush, sb_set_en, rf_wr_en;
    logic [NREG-1:0] sb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .flush(flush), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        bit          fl;
        bit          se;
        logic [4:0]  sa;
        bit          er0, er1, ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    // Behavioural model: who won last, the write-port contents, pending set.
    bit          m_last_req1;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_busy [NREG];

    function automatic vec_t mk(bit v0, logic [4:0] a0, logic [31:0] d0,
                                bit v1, logic [4:0] a1, logic [31:0] d1,
                                bit fl, bit se, logic [4:0] sa,
                                bit er0, bit er1, bit ewe, logic [4:0] ewa,
                                logic [31:0] ewd, logic [31:0] ebusy);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.fl = fl; v.se = se; v.sa = sa; v.er0 = er0; v.er1 = er1;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] r = '0;
        for (int k = 0; k < NREG; k++) r[k] = m_busy[k];
        return r;
    endfunction

    task automatic m_reset();
        m_last_req1 = 1'b1;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
    endtask

    // Who the arbiter should grant for these inputs.
    task automatic m_grant(input vec_t e, output bit g0, output bit g1);
        g0 = 1'b0; g1 = 1'b0;
        if (!e.fl) begin
            if (e.v0 && e.v1) begin
                if (m_last_req1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = e.v0; g1 = e.v1;
            end
        end
    endtask

    // Apply one cycle of the model at a clock edge.
    task automatic m_edge(input vec_t e);
        bit g0, g1;
        m_grant(e, g0, g1);
        m_we = 1'b0;
        if (g0 || g1) begin
            m_wa = g0 ? e.a0 : e.a1;
            m_wd = g0 ? e.d0 : e.d1;
            m_we = (m_wa != 0);
            m_last_req1 = g1;
            m_busy[m_wa] = 1'b0;
        end
        if (e.fl) begin
            for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
        end else if (e.se && e.sa != 0) begin
            m_busy[e.sa] = 1'b1;
        end
    endtask

    // Drive at negedge, check readies, clock, check registered outputs.
    task automatic run_cycle(input vec_t e, input bit use_tbl, input int idx);
        bit g0, g1;
        @(negedge clk);
        req0_valid = e.v0; req0_addr = e.a0; req0_data = e.d0;
        req1_valid = e.v1; req1_addr = e.a1; req1_data = e.d1;
        flush = e.fl; sb_set_en = e.se; sb_set_addr = e.sa;
        #1;
        m_grant(e, g0, g1);
        chk($sformatf("ready0 c%0d", idx), req0_ready, g0);
        chk($sformatf("ready1 c%0d", idx), req1_ready, g1);
        if (use_tbl) begin
            chk($sformatf("tbl ready0 r%0d", idx), req0_ready, e.er0);
            chk($sformatf("tbl ready1 r%0d", idx), req1_ready, e.er1);
        end
        @(posedge clk);
        m_edge(e);
        #1;
        chk($sformatf("wr_en c%0d", idx), rf_wr_en, m_we);
        chk($sformatf("wr_addr c%0d", idx), rf_wr_addr, m_wa);
        chk($sformatf("wr_data c%0d", idx), rf_wr_data, m_wd);
        chk($sformatf("sb_busy c%0d", idx), sb_busy, m_busy_vec());
        if (use_tbl) begin
            chk($sformatf("tbl wr_en r%0d", idx), rf_wr_en, e.ewe);
            chk($sformatf("tbl wr_addr r%0d", idx), rf_wr_addr, e.ewa);
            chk($sformatf("tbl wr_data r%0d", idx), rf_wr_data, e.ewd);
            chk($sformatf("tbl sb_busy r%0d", idx), sb_busy, e.ebusy);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        flush = 0; sb_set_en = 0; sb_set_addr = '0;
    endtask

    localparam logic [31:0] DA = 32'hA0A0_0003;
    localparam logic [31:0] DB = 32'hB0B0_0007;
    localparam logic [31:0] DE = 32'hDEAD_BEEF;

    vec_t tbl [16];
    vec_t rv;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          v0 a0 d0          v1 a1 d1   fl se sa  r0 r1 we wa  wd            busy
        tbl[0]  = mk(1, 3, DA,        1, 7, DB,   0, 0, 0,  1, 0, 1, 3,  DA,           32'h0);
        tbl[1]  = mk(1, 3, DA,        1, 7, DB,   0, 0, 0,  0, 1, 1, 7,  DB,           32'h0);
        tbl[2]  = mk(1, 3, DA,        1, 7, DB,   0, 0, 0,  1, 0, 1, 3,  DA,           32'h0);
        tbl[3]  = mk(1, 3, DA,        1, 7, DB,   0, 0, 0,  0, 1, 1, 7,  DB,           32'h0);
        tbl[4]  = mk(0, 0, 0,         1, 0, DE,   0, 0, 0,  0, 1, 0, 0,  DE,           32'h0);
        tbl[5]  = mk(0, 0, 0,         0, 0, 0,    0, 1, 5,  0, 0, 0, 0,  DE,           32'h20);
        tbl[6]  = mk(0, 0, 0,         0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  DE,           32'h20);
        tbl[7]  = mk(0, 0, 0,         0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  DE,           32'h20);
        tbl[8]  = mk(1, 5, 32'h55,    0, 0, 0,    0, 0, 0,  1, 0, 1, 5,  32'h55,       32'h0);
        tbl[9]  = mk(0, 0, 0,         0, 0, 0,    0, 1, 9,  0, 0, 0, 5,  32'h55,       32'h200);
        tbl[10] = mk(0, 0, 0,         1, 9, 32'h99, 0, 1, 9, 0, 1, 1, 9, 32'h99,       32'h200);
        tbl[11] = mk(0, 0, 0,         0, 0, 0,    0, 1, 8,  0, 0, 0, 9,  32'h99,       32'h300);
        tbl[12] = mk(0, 0, 0,         0, 0, 0,    0, 1, 10, 0, 0, 0, 9,  32'h99,       32'h700);
        tbl[13] = mk(1, 4, 32'h44,    0, 0, 0,    0, 1, 11, 1, 0, 1, 4,  32'h44,       32'hF00);
        tbl[14] = mk(1, 3, DA,        1, 7, DB,   1, 1, 6,  0, 0, 0, 4,  32'h44,       32'h0);
        tbl[15] = mk(1, 3, DA,        1, 7, DB,   0, 0, 0,  0, 1, 1, 7,  DB,           32'h0);

        // Reset state.
        drive_idle();
        nrst = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset wr_en", rf_wr_en, 1'b0);
        chk("reset wr_addr", rf_wr_addr, 5'd0);
        chk("reset wr_data", rf_wr_data, 32'd0);
        chk("reset sb_busy", sb_busy, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        for (int r = 0; r < 16; r++) run_cycle(tbl[r], 1'b1, r);

        // Reset asserted between edges while writes are active.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0), 1'b0, 100);
        run_cycle(mk(1, 3, DA, 1, 7, DB, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 101);
        chk("pre-reset wr_en", rf_wr_en, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async reset wr_en", rf_wr_en, 1'b0);
        chk("async reset wr_addr", rf_wr_addr, 5'd0);
        chk("async reset wr_data", rf_wr_data, 32'd0);
        chk("async reset sb_busy", sb_busy, 32'd0);
        m_reset();
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-release wr_en", rf_wr_en, 1'b0);
        run_cycle(mk(1, 3, DA, 1, 7, DB, 0, 0, 0, 1, 0, 1, 3, DA, 32'h0), 1'b1, 200);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rv = mk(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 99) < 8), ($urandom_range(0, 9) < 4),
                    5'($urandom_range(0, 31)), 0, 0, 0, 0, 0, 0);
            run_cycle(rv, 1'b0, 1000 + c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
